seq_mul_hs: RTL and testbench

- Parametrised, iterative shift-add multiplier. It is the sequential successor to the 8-bit combinational multiplier.
- Operand width is generic and each operation selects signed or unsigned mode.
- Operands come in and the product goes out over valid/ready handshakes.
- Cost is one adder of WIDTH+1 bits instead of a full array. It sits between the pad-level I/O wrapper and any stream source or sink in the top level.

---
 rtl/seq_mul_hs.sv | 143 ++++++++++++++
 tb/tb_seq_mul_hs.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_hs.sv
// -----------------------------------------------------------------------------
// seq_mul_hs - iterative shift-add multiplier with valid/ready handshakes.
//
// Consumes one multiplier bit per clock using a single WIDTH+1-bit adder.
// The operation is data-independent: the product is presented exactly WIDTH
// clock edges after the operands are accepted.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. in_ready is high only in IDLE, and out_valid
// is high only in DONE. Both are decodes of registered state, so there is
// no combinational path from any input to any output.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high; discards any in-flight operation
//   in_valid   - operand pair valid
//   in_ready   - block can accept operands (IDLE only)
//   in_a       - multiplicand, WIDTH bits
//   in_b       - multiplier, WIDTH bits
//   in_signed  - 1: two's-complement operands, 0: unsigned (sampled at accept)
//   out_valid  - product valid (DONE only)
//   out_ready  - downstream accepts product
//   out_prod   - product, 2*WIDTH bits, held until the next DONE entry or reset
//   busy       - high in RUN or DONE
// -----------------------------------------------------------------------------
module seq_mul_hs #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Upper half: partial product; lower half: remaining multiplier bits.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     a_neg;
    logic [WIDTH-1:0]     b_neg;
    logic [WIDTH-1:0]     a_mag_in;
    logic [WIDTH-1:0]     b_mag_in;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;

    // Magnitudes of the incoming operands. The most-negative value negates to
    // itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        a_neg    = -in_a;
        b_neg    = -in_b;
        a_mag_in = (in_signed && in_a[WIDTH-1]) ? a_neg : in_a;
        b_mag_in = (in_signed && in_b[WIDTH-1]) ? b_neg : in_b;
    end

    // One shift-add step: conditionally add |a| into the upper half with the
    // carry kept, then shift the whole accumulator right by one.
    always_comb begin
        addend    = acc_q[0] ? a_mag_q : '0;
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_shift = {sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_mag_d = a_mag_q;
        neg_d   = neg_q;
        prod_d  = prod_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_mag_d = a_mag_in;
                    acc_d   = {{WIDTH{1'b0}}, b_mag_in};
                    neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // A zero magnitude negates to zero, so no negative zero.
                    prod_d  = neg_q ? -acc_shift : acc_shift;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_mag_q <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_mag_q <= a_mag_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_prod  = prod_q;

endmodule

// File: tb/tb_seq_mul_hs.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_hs - directed and randomised checks of seq_mul_hs at WIDTH=8 and
// WIDTH=16. Inputs change 1 time unit after a rising edge, and outputs are
// sampled at that same point, so nothing is read on the active edge.
// -----------------------------------------------------------------------------
module tb_seq_mul_hs;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT wiring ----------------
    logic [15:0] a_bus, b_bus;
    logic        s_bus;
    logic        iv8, iv16, or8, or16;
    logic        ir8, ov8, busy8;
    logic [15:0] p8;
    logic        ir16, ov16, busy16;
    logic [31:0] p16;

    seq_mul_hs #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_a      (a_bus[7:0]),
        .in_b      (b_bus[7:0]),
        .in_signed (s_bus),
        .out_valid (ov8),
        .out_ready (or8),
        .out_prod  (p8),
        .busy      (busy8)
    );

    seq_mul_hs #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in_a      (a_bus),
        .in_b      (b_bus),
        .in_signed (s_bus),
        .out_valid (ov16),
        .out_ready (or16),
        .out_prod  (p16),
        .busy      (busy16)
    );

    // Selected-instance views so one driver serves both widths.
    logic        sel16;
    logic        m_ir, m_ov, m_busy;
    logic [31:0] m_prod;
    always_comb begin
        m_ir   = sel16 ? ir16   : ir8;
        m_ov   = sel16 ? ov16   : ov8;
        m_busy = sel16 ? busy16 : busy8;
        m_prod = sel16 ? p16    : {16'h0000, p8};
    end

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product, written independently of the shift-add structure.
    function automatic logic [31:0] ref_mul(input logic w16, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
        longint sa, sb, p;
        if (w16) begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
        end else begin
            sa = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            sb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end
        p = sa * sb;
        return w16 ? p[31:0] : {16'h0000, p[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, latency/ready checks, optional backpressure
    // gap, output handshake, and post-handshake checks.
    task automatic run_op(input logic w16, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] exp, input int gap,
                          input string name);
        int          lat;
        logic        ready_low;
        logic        stable;
        logic [31:0] held;
        sel16 = w16;
        a_bus = a;
        b_bus = b;
        s_bus = s;
        check({name, " idle_ready"}, 32'(m_ir), 32'd1);
        if (w16) iv16 = 1'b1; else iv8 = 1'b1;
        tick;
        iv8  = 1'b0;
        iv16 = 1'b0;
        exp_q.push_back(exp);
        lat       = 0;
        ready_low = 1'b1;
        while (!m_ov && lat < 40) begin
            if (m_ir || !m_busy) ready_low = 1'b0;
            tick;
            lat++;
        end
        check({name, " latency"}, 32'(lat), w16 ? 32'd16 : 32'd8);
        check({name, " ready_low_busy"}, 32'(ready_low && !m_ir && m_busy), 32'd1);
        held   = m_prod;
        stable = 1'b1;
        for (int i = 0; i < gap; i++) begin
            tick;
            if (m_prod !== held || !m_ov) stable = 1'b0;
        end
        check({name, " hold_stable"}, 32'(stable), 32'd1);
        if (w16) or16 = 1'b1; else or8 = 1'b1;
        tick;
        or8  = 1'b0;
        or16 = 1'b0;
        check({name, " product"}, held, exp_q.pop_front());
        check({name, " valid_drop"}, 32'(m_ov), 32'd0);
        check({name, " prod_retained"}, m_prod, held);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          lat;
        logic        flag;
        logic [15:0] ra, rb;
        logic        rs;

        vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, "u_13x11"};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, "u_255x255"};
        vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000, "u_0x200"};
        vecs[3] = '{8'd1,   8'd255, 1'b0, 16'h00FF, "u_1x255"};
        vecs[4] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1, "s_m3x5"};
        vecs[5] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128"};
        vecs[6] = '{8'h80,  8'h7F,  1'b1, 16'hC080, "s_m128x127"};
        vecs[7] = '{8'h80,  8'h80,  1'b0, 16'h4000, "u_128x128"};
        vecs[8] = '{8'h00,  8'hFB,  1'b1, 16'h0000, "s_0xm5"};
        vecs[9] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, "s_m1xm1"};

        reset = 1'b1;
        iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b0; or16 = 1'b0;
        a_bus = '0; b_bus = '0; s_bus = 1'b0; sel16 = 1'b0;
        tick;
        tick;
        reset = 1'b0;

        // Reset state, both widths.
        check("rst8_in_ready",   32'(ir8),   32'd1);
        check("rst8_out_valid",  32'(ov8),   32'd0);
        check("rst8_busy",       32'(busy8), 32'd0);
        check("rst8_prod",       32'(p8),    32'd0);
        check("rst16_in_ready",  32'(ir16),  32'd1);
        check("rst16_out_valid", 32'(ov16),  32'd0);
        check("rst16_prod",      p16,        32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].s,
                   {16'h0000, vecs[i].exp}, i % 3, vecs[i].name);
        end

        // Backpressure: 20 cycles in DONE with in_valid/in_a toggling.
        sel16 = 1'b0;
        a_bus = 16'd13; b_bus = 16'd11; s_bus = 1'b0;
        iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        repeat (8) tick;
        check("bp_enter_done", 32'(ov8), 32'd1);
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            iv8   = i[0];
            a_bus = 16'($urandom_range(0, 255));
            s_bus = i[1];
            tick;
            if (p8 !== 16'h008F || !ov8 || ir8) flag = 1'b0;
        end
        check("bp_hold", 32'(flag), 32'd1);
        check("bp_prod", 32'(p8), 32'h008F);

        // Handshake cycle with in_valid high must not accept.
        a_bus = 16'd6; b_bus = 16'd7; s_bus = 1'b0;
        iv8 = 1'b1;
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
        check("hs_no_accept_valid", 32'(ov8), 32'd0);
        check("hs_no_accept_ready", 32'(ir8), 32'd1);
        tick;
        iv8 = 1'b0;
        check("next_accept_busy", 32'({busy8, ir8}), 32'b10);
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick;
            lat++;
        end
        check("next_accept_latency", 32'(lat), 32'd8);
        check("next_accept_prod", 32'(p8), 32'h002A);
        or8 = 1'b1;
        tick;
        or8 = 1'b0;

        // Reset three cycles into RUN.
        a_bus = 16'd200; b_bus = 16'd3; s_bus = 1'b0;
        iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        repeat (3) tick;
        check("pre_reset_busy", 32'(busy8), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_in_ready",  32'(ir8),   32'd1);
        check("midrst_out_valid", 32'(ov8),   32'd0);
        check("midrst_busy",      32'(busy8), 32'd0);
        check("midrst_prod",      32'(p8),    32'd0);
        flag = 1'b1;
        repeat (12) begin
            tick;
            if (ov8 || busy8) flag = 1'b0;
        end
        check("midrst_no_output", 32'(flag), 32'd1);
        run_op(1'b0, 16'd6, 16'd7, 1'b0, 32'h0000_002A, 0, "post_rst_6x7");

        // Random regression, both widths.
        for (int n = 0; n < 1000; n++) begin
            logic w;
            w  = (n >= 650);
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if (!w) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            rs = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick;
            run_op(w, ra, rb, rs, ref_mul(w, ra, rb, rs), $urandom_range(0, 3), "rand");
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
